// File: rtl/aes_rcon_seq_pkg.sv
// Shared AES key-schedule definitions.
//   aes_klen_e  : key length selector as seen on the key_len input
//   rcon_st_e   : round-constant sequencer states
//   rcon_count  : number of rcon words consumed by a key length
//   rcon_final  : last rcon byte of the forward sequence, i.e. the first
//                 byte when the schedule is walked in reverse
package aes_rcon_seq_pkg;

  typedef enum logic [1:0] {
    AES128   = 2'b00,
    AES192   = 2'b01,
    AES256   = 2'b10,
    AES_RSVD = 2'b11
  } aes_klen_e;

  typedef enum logic [1:0] {
    RC_IDLE = 2'b00,
    RC_RUN  = 2'b01,
    RC_DONE = 2'b10
  } rcon_st_e;

  // GF(2^8) reduction polynomial (x^8 + x^4 + x^3 + x + 1, low byte).
  localparam logic [7:0] AES_POLY     = 8'h1B;
  // Correction term applied when dividing an odd value by x: (0x11B >> 1).
  localparam logic [7:0] AES_INV_POLY = 8'h8D;

  // Reserved key length falls back to AES-128.
  function automatic logic [3:0] rcon_count(aes_klen_e k);
    case (k)
      AES192:  return 4'd8;
      AES256:  return 4'd7;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon_final(aes_klen_e k);
    case (k)
      AES192:  return 8'h80;
      AES256:  return 8'h40;
      default: return 8'h36;
    endcase
  endfunction

endpackage

// File: rtl/aes_rcon_seq_if.sv
// Handshake bundle between key-load control / key-expand datapath (master)
// and the round-constant sequencer (slave).
//   kld, key_len, dec, step : master -> sequencer
//   rcon_o, valid, idx,
//   last, done              : sequencer -> master
interface aes_rcon_seq_if #(
  parameter int WORD_W = 32
);
  logic              kld;
  logic [1:0]        key_len;
  logic              dec;
  logic              step;
  logic [WORD_W-1:0] rcon_o;
  logic              valid;
  logic [3:0]        idx;
  logic              last;
  logic              done;

  modport master (
    output kld, key_len, dec, step,
    input  rcon_o, valid, idx, last, done
  );

  modport slave (
    input  kld, key_len, dec, step,
    output rcon_o, valid, idx, last, done
  );
endinterface

// File: rtl/aes_gf_xtime.sv
// Combinational multiply / divide by x in GF(2^8) with the AES polynomial.
//   in_b  : operand byte
//   inv   : 0 = multiply by x (xtime), 1 = divide by x (inverse xtime)
//   out_b : result byte
module aes_gf_xtime
  import aes_rcon_seq_pkg::*;
(
  input  logic [7:0] in_b,
  input  logic       inv,
  output logic [7:0] out_b
);

  always_comb begin
    out_b = '0;
    if (inv) begin
      // An odd value had the polynomial folded in on the way up; undo it.
      out_b = {1'b0, in_b[7:1]} ^ (in_b[0] ? AES_INV_POLY : 8'h00);
    end else begin
      out_b = {in_b[6:0], 1'b0} ^ (in_b[7] ? AES_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/aes_rcon_seq.sv
// Round-constant sequencer for AES-128/192/256 key expansion.
// Emits the rcon word sequence in forward or reverse order, one word per
// accepted step, restarting on every key load.
//   clk, rst_n : clock, asynchronous active-low reset
//   rc (slave) : kld/key_len/dec/step in; rcon_o/valid/idx/last/done out
// Parameters:
//   WORD_W     : width of rcon_o (>= 8, multiple of 8)
//   RCON_LANE  : byte lane of rcon_o carrying the constant; others are 0
module aes_rcon_seq
  import aes_rcon_seq_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int RCON_LANE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_rcon_seq_if.slave rc
);

  rcon_st_e  state_q, state_d;
  aes_klen_e klen_q,  klen_d;
  logic      dec_q,   dec_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] idx_q,  idx_d;
  logic       last_q, last_d;

  aes_klen_e   klen_in;
  logic [7:0]  byte_adv;
  logic [3:0]  idx_nxt;
  logic [3:0]  idx_end;
  logic [WORD_W-1:0] rcon_word;

  // Next byte is derived from the current one; no table of constants.
  aes_gf_xtime u_xtime (
    .in_b  (byte_q),
    .inv   (dec_q),
    .out_b (byte_adv)
  );

  assign klen_in = (aes_klen_e'(rc.key_len) == AES_RSVD) ? AES128
                                                         : aes_klen_e'(rc.key_len);
  assign idx_nxt = idx_q + 4'd1;
  assign idx_end = rcon_count(klen_q) - 4'd1;

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    dec_d   = dec_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    last_d  = last_q;

    if (rc.kld) begin
      // Key load overrides any step presented in the same cycle.
      state_d = RC_RUN;
      klen_d  = klen_in;
      dec_d   = rc.dec;
      idx_d   = '0;
      byte_d  = rc.dec ? rcon_final(klen_in) : 8'h01;
      last_d  = 1'b0;
    end else if (state_q == RC_RUN && rc.step) begin
      if (last_q) begin
        // idx holds at N-1 so the consumer can see where the sequence ended.
        state_d = RC_DONE;
        byte_d  = '0;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_nxt;
        byte_d = byte_adv;
        last_d = (idx_nxt == idx_end);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RC_IDLE;
      klen_q  <= AES128;
      dec_q   <= 1'b0;
      byte_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      dec_q   <= dec_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    rcon_word = '0;
    rcon_word[RCON_LANE*8 +: 8] = byte_q;
  end

  // All outputs are flops or decodes of flops only.
  assign rc.rcon_o = rcon_word;
  assign rc.valid  = (state_q == RC_RUN);
  assign rc.done   = (state_q == RC_DONE);
  assign rc.idx    = idx_q;
  assign rc.last   = last_q;

endmodule
